// File: rtl/bcd_display_pkg.sv
// Shared constants for the 4-digit BCD scan display: digit count,
// 7-segment patterns ({g,f,e,d,c,b,a}, active-high) and the all-off anode code.
package bcd_display_pkg;

   localparam int NUM_DIGITS = 4;

   localparam logic [6:0] SEG_0     = 7'b0111111;
   localparam logic [6:0] SEG_1     = 7'b0000110;
   localparam logic [6:0] SEG_2     = 7'b1011011;
   localparam logic [6:0] SEG_3     = 7'b1001111;
   localparam logic [6:0] SEG_4     = 7'b1100110;
   localparam logic [6:0] SEG_5     = 7'b1101101;
   localparam logic [6:0] SEG_6     = 7'b1111101;
   localparam logic [6:0] SEG_7     = 7'b0000111;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1101111;
   localparam logic [6:0] SEG_DASH  = 7'b1000000;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   localparam logic [3:0] DIGIT_OFF = 4'b1111;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to 7-segment decoder; non-BCD codes show a dash.
module bcd_to_7seg
   import bcd_display_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   // Map each nibble to its segment pattern, dash for 10..15.
   always_comb begin
      seg = SEG_DASH;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/bcd_display_scan.sv
// MM:SS BCD shadow register time-multiplexed onto a common-anode 4-digit
// display, with leading-zero blanking of the min-tens digit and whole-display
// blinking. Outputs are registered, so every change shows up one cycle later.
module bcd_display_scan
   import bcd_display_pkg::*;
#(
   parameter int REFRESH_DIV = 50000,
   parameter int BLINK_TICKS = 250
)(
   input  logic        clk,
   input  logic        resetn,
   input  logic [15:0] digits,
   input  logic        load,
   input  logic        enablen,
   input  logic        blank_lz,
   input  logic        blink,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  an_n
);

   localparam int PRE_W = $clog2(REFRESH_DIV);
   localparam int BLK_W = $clog2(BLINK_TICKS + 1);
   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(REFRESH_DIV - 1);
   localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_TICKS - 1);

   logic [15:0]      shadow_q, shadow_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [BLK_W-1:0] bcnt_q, bcnt_d;
   logic             phase_q, phase_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;
   logic [3:0]       an_q, an_d;

   logic             tick;
   logic [3:0]       nibble;
   logic [6:0]       seg_dec;
   logic             dark;

   bcd_to_7seg u_dec (
      .bcd (nibble),
      .seg (seg_dec)
   );

   // Next-state for shadow, prescaler, scan index, blink timer and output stage.
   always_comb begin
      shadow_d = load ? digits : shadow_q;

      tick  = (pre_q == PRE_MAX);
      pre_d = tick ? '0 : pre_q + 1'b1;
      idx_d = tick ? idx_q + 1'b1 : idx_q;

      // Holding blink low parks the timer so a new blink starts visible.
      bcnt_d  = bcnt_q;
      phase_d = phase_q;
      if (!blink) begin
         bcnt_d  = '0;
         phase_d = 1'b0;
      end else if (tick) begin
         if (bcnt_q == BLK_MAX) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
         end else begin
            bcnt_d = bcnt_q + 1'b1;
         end
      end

      nibble = shadow_q[3:0];
      case (idx_q)
         2'd0:    nibble = shadow_q[15:12];
         2'd1:    nibble = shadow_q[11:8];
         2'd2:    nibble = shadow_q[7:4];
         default: nibble = shadow_q[3:0];
      endcase

      dark = enablen
           | (blink & phase_q)
           | (blank_lz & (idx_q == 2'd0) & (shadow_q[15:12] == 4'd0));

      an_d  = dark ? DIGIT_OFF : ~(4'b1000 >> idx_q);
      seg_d = dark ? SEG_BLANK : seg_dec;
      // The decimal point after min units forms the MM.SS separator.
      dp_d  = ~dark & (idx_q == 2'd1);
   end

   // State and output registers; reset overrides load and blanks the display.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         shadow_q <= '0;
         pre_q    <= '0;
         idx_q    <= '0;
         bcnt_q   <= '0;
         phase_q  <= 1'b0;
         seg_q    <= SEG_BLANK;
         dp_q     <= 1'b0;
         an_q     <= DIGIT_OFF;
      end else begin
         shadow_q <= shadow_d;
         pre_q    <= pre_d;
         idx_q    <= idx_d;
         bcnt_q   <= bcnt_d;
         phase_q  <= phase_d;
         seg_q    <= seg_d;
         dp_q     <= dp_d;
         an_q     <= an_d;
      end
   end

   assign seg  = seg_q;
   assign dp   = dp_q;
   assign an_n = an_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Bench for bcd_display_scan with REFRESH_DIV=4, BLINK_TICKS=2.
// A phase table gives inputs and the hand-written segment pattern of each slot;
// a small timing model predicts the slot/darkness, pushes the expected outputs
// into a queue when the inputs are driven and pops them after the clock edge.
module tb_bcd_display_scan;

   localparam logic [6:0] S0 = 7'h3F, S1 = 7'h06, S2 = 7'h5B, S3 = 7'h4F;
   localparam logic [6:0] S4 = 7'h66, S5 = 7'h6D, S9 = 7'h6F, SD = 7'h40;
   localparam logic [3:0] AN_TBL [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

   logic        clk = 1'b0;
   logic        resetn, load, enablen, blank_lz, blink;
   logic [15:0] digits;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an_n;

   bcd_display_scan #(.REFRESH_DIV(4), .BLINK_TICKS(2)) dut (
      .clk      (clk),
      .resetn   (resetn),
      .digits   (digits),
      .load     (load),
      .enablen  (enablen),
      .blank_lz (blank_lz),
      .blink    (blink),
      .seg      (seg),
      .dp       (dp),
      .an_n     (an_n)
   );

   always #5 clk = ~clk;

   typedef struct {
      string           name;
      logic [15:0]     digits;
      logic            ld;
      logic            en_n;
      logic            blz;
      logic            blk;
      int              cycles;
      logic [3:0][6:0] seg_exp;   // [k] = pattern shown in scan slot k
   } vec_t;

   vec_t tbl [8];

   int n_vec = 0;
   int n_err = 0;
   logic [11:0] exp_q [$];

   // reference timing model
   int          m_cnt, m_idx, m_bc, m_row, cur_row;
   bit          m_ph;
   logic [15:0] m_sh;

   task automatic chk(input string nm, input logic [11:0] got, input logic [11:0] req);
      n_vec++;
      if (got !== req) begin
         n_err++;
         $display("FAIL %s: got an_n/seg/dp=%b required %b (t=%0t)", nm, got, req, $time);
      end
   endtask

   function automatic logic [11:0] model_out();
      bit dk;
      if (!resetn) return {4'b1111, 7'b0, 1'b0};
      dk = enablen || (blink && m_ph) || (blank_lz && m_idx == 0 && m_sh[15:12] == 4'd0);
      if (dk) return {4'b1111, 7'b0, 1'b0};
      return {AN_TBL[m_idx], tbl[m_row].seg_exp[m_idx], (m_idx == 1)};
   endfunction

   task automatic model_edge();
      bit tk;
      if (!resetn) begin
         m_cnt = 0; m_idx = 0; m_bc = 0; m_ph = 0; m_sh = 16'h0; m_row = 0;
      end else begin
         if (load) begin m_sh = digits; m_row = cur_row; end
         tk = (m_cnt == 3);
         m_cnt = tk ? 0 : m_cnt + 1;
         if (tk) m_idx = (m_idx + 1) % 4;
         if (!blink) begin
            m_bc = 0; m_ph = 0;
         end else if (tk) begin
            if (m_bc == 1) begin m_bc = 0; m_ph = !m_ph; end
            else m_bc = m_bc + 1;
         end
      end
   endtask

   // Called with inputs already settled: push expectation, clock, pop and compare.
   task automatic step(input string nm);
      logic [11:0] e;
      exp_q.push_back(model_out());
      @(posedge clk);
      model_edge();
      #1;
      if (exp_q.size() == 0) begin
         n_vec++; n_err++;
         $display("FAIL %s: scoreboard empty", nm);
      end else begin
         e = exp_q.pop_front();
         chk(nm, {an_n, seg, dp}, e);
      end
      @(negedge clk);
   endtask

   function automatic vec_t mk(string nm, logic [15:0] d, logic ld, logic en_n, logic blz,
                               logic blk, int cyc, logic [3:0][6:0] se);
      vec_t v;
      v.name = nm; v.digits = d; v.ld = ld; v.en_n = en_n; v.blz = blz;
      v.blk = blk; v.cycles = cyc; v.seg_exp = se;
      return v;
   endfunction

   initial begin
      int guard, vis, drk;
      logic [11:0] got;

      tbl[0] = mk("zeros",     16'h0000, 1, 0, 0, 0, 16, {S0, S0, S0, S0});
      tbl[1] = mk("scan_1234", 16'h1234, 1, 0, 0, 0, 32, {S4, S3, S2, S1});
      tbl[2] = mk("bad_bcd",   16'h9AF0, 1, 0, 0, 0, 16, {S0, SD, SD, S9});
      tbl[3] = mk("lz_blank",  16'h0305, 1, 0, 1, 0, 16, {S5, S0, S3, S0});
      tbl[4] = mk("lz_show",   16'h0305, 1, 0, 0, 0, 16, {S5, S0, S3, S0});
      tbl[5] = mk("blink",     16'h1234, 1, 0, 0, 1, 40, {S4, S3, S2, S1});
      tbl[6] = mk("en_off",    16'h4321, 1, 1, 0, 0, 12, {S1, S2, S3, S4});
      tbl[7] = mk("en_on",     16'h4321, 0, 0, 0, 0, 16, {S1, S2, S3, S4});

      resetn = 0; load = 0; enablen = 0; blank_lz = 0; blink = 0; digits = 16'h0;
      cur_row = 0;
      m_cnt = 0; m_idx = 0; m_bc = 0; m_ph = 0; m_sh = 16'h0; m_row = 0;
      @(negedge clk);

      // reset: two cycles dark
      repeat (2) step("reset");
      resetn = 1;

      // table-driven phases
      for (int r = 0; r < 8; r++) begin
         cur_row  = r;
         digits   = tbl[r].digits;
         load     = tbl[r].ld;
         enablen  = tbl[r].en_n;
         blank_lz = tbl[r].blz;
         blink    = tbl[r].blk;
         step(tbl[r].name);
         load = 0;
         for (int c = 1; c < tbl[r].cycles; c++) step(tbl[r].name);
      end

      // blink: starting at a slot boundary, exactly 8 visible then 8 dark
      blink = 0; enablen = 0; blank_lz = 0;
      guard = 0;
      while (m_cnt != 0 && guard < 10) begin step("blink_align"); guard++; end
      blink = 1;
      vis = 0; drk = 0;
      for (int c = 0; c < 8; c++) begin step("blink_seq"); if (an_n != 4'hF) vis++; end
      for (int c = 0; c < 8; c++) begin step("blink_seq"); if (an_n == 4'hF) drk++; end
      chk("blink_visible_half", 12'(vis), 12'd8);
      chk("blink_dark_half", 12'(drk), 12'd8);
      for (int c = 0; c < 12; c++) step("blink_seq2");   // 8 visible + 4 into dark
      chk("blink_mid_dark", {an_n, seg, dp}, {4'b1111, 7'b0, 1'b0});
      blink = 0;
      step("blink_drop");
      chk("blink_restore", 12'(an_n != 4'hF), 12'd1);

      // reset during scan index 2 with a simultaneous load
      cur_row = 1; digits = 16'h8888;
      guard = 0;
      while (m_idx != 2 && guard < 20) begin step("rst_align"); guard++; end
      if (m_idx != 2) begin
         n_vec++; n_err++;
         $display("FAIL rst_align: index 2 not reached got %0d required 2", m_idx);
      end
      resetn = 0; load = 1;
      step("rst_mid");
      got = {an_n, seg, dp};
      chk("rst_mid_dark", got, {4'b1111, 7'b0, 1'b0});
      resetn = 1; load = 0;
      step("rst_release");
      chk("rst_restart_idx0", {an_n, seg, dp}, {4'b0111, S0, 1'b0});
      repeat (15) step("rst_shadow_zero");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // absolute time limit so the run always ends
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got no end required end");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/bcd_display_scan.md
Name: bcd_display_scan

Overview:
- Output-side counterpart of the keypad encoder in the timer control path: the encoder turns keypresses into BCD, and this block turns stored BCD digits back into visible 7-segment patterns.
- Holds a 4-digit BCD value (MM:SS) in a shadow register, time-multiplexes it onto a common-anode 4-digit display with a scan counter, and supports leading-zero blanking and whole-display blinking (e.g. "time up" or "paused").

Parameters:
- REFRESH_DIV, 50000, clk cycles per digit slot; legal range is 2 or more.
- BLINK_TICKS, 250, scan ticks per blink half-period; legal range is 1 or more.

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  synchronous active-low reset
- digits  in  16  BCD digits, [15:12]=min tens, [11:8]=min units, [7:4]=sec tens, [3:0]=sec units
- load  in  1  when high, capture digits into the shadow register this edge
- enablen  in  1  active-low display enable; when high, all digits are dark
- blank_lz  in  1  when high, blank the min-tens digit if it is 0
- blink  in  1  when high, blink the whole display
- seg  out  7  segments {g,f,e,d,c,b,a}, active-high
- dp  out  1  decimal point, active-high; lit only on the min-units digit as the MM.SS separator
- an_n  out  4  digit enables, active-low, one-hot-low; an_n[3] is min tens

Behaviour:
- Reset: resetn=0 at a rising edge sets the following, overriding everything else, including a simultaneous load:
  - shadow=16'h0000, prescaler=0, scan index=0, blink phase=0, blink counter=0
  - seg=7'b0000000, dp=0, an_n=4'b1111
- Shadow register:
  - load=1 captures digits at the edge.
  - load=0 holds the previous value.
  - load is sampled every cycle regardless of enablen.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps. The scan tick is the cycle where count==REFRESH_DIV-1.
- Scan index (2 bits):
  - Increments on each tick, wrapping 3->0.
  - Index 0 selects min tens (an_n[3]); index 3 selects sec units (an_n[0]).
- Output stage:
  - seg, dp and an_n are registered from the current index, shadow, enablen, blank_lz, blink and blink phase.
  - A load or index change therefore appears on the outputs exactly 1 cycle later.
- Decode of the selected nibble:
  - 0..9 give the standard patterns.
  - 10..15 give a dash (g only, 7'b1000000).
- The selected digit is dark (an_n=4'b1111, seg=0, dp=0) when any of the following holds:
  - enablen=1
  - blink=1 and blink phase=1
  - blank_lz=1, index=0 and the min-tens nibble is 0
- Otherwise, an_n = ~(4'b1000 >> index).
- Blink:
  - The counter counts scan ticks 0..BLINK_TICKS-1; when a tick lands on the terminal count, phase toggles and the counter wraps.
  - blink=0 forces counter=0 and phase=0, so blinking always begins with a visible half-period.
- Boundaries:
  - load during a tick: the new shadow and the new index take effect together on the next edge.
  - Prescaler and scan continue while enablen=1, so re-enabling resumes without a phase jump.
  - resetn mid-scan restarts at index 0 with a dark display for 1 cycle.

Decomposition:
- Shared package bcd_display_pkg holds:
  - NUM_DIGITS=4
  - segment constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK
  - DIGIT_OFF=4'b1111
- One combinational sub-module, bcd_to_7seg (4-bit in, 7-bit out, dash for nibbles above 9), instantiated once on the muxed nibble.

Test Plan (REFRESH_DIV=4, BLINK_TICKS=2):
- Reset and scan order:
  - Stimulus: resetn=0 for 2 cycles, then load digits=16'h1234 with enablen=0.
  - Required: outputs dark during reset; then an_n sequence 0111,1011,1101,1110, each held 4 cycles, repeating.
  - Required seg per slot: SEG_1, SEG_2+dp=1, SEG_3, SEG_4.
- Invalid BCD:
  - Stimulus: load 16'h9AF0.
  - Required seg per slot: SEG_9, 7'b1000000, 7'b1000000, SEG_0.
- Leading-zero blanking:
  - Stimulus: load 16'h0305 with blank_lz=1.
  - Required: slot 0 has an_n=1111 and seg=0; the other slots show 3(dp), 0, 5.
  - With blank_lz=0, slot 0 shows SEG_0.
- Blink:
  - Stimulus: blink=1.
  - Required: 8 visible cycles (2 ticks), then 8 dark cycles, alternating.
  - Dropping blink mid-dark restores output 1 cycle later.
- enablen and load:
  - Stimulus: enablen=1 while loading 16'h4321.
  - Required: an_n stays 1111.
  - After enablen=0, the next slot shows the 4321 digit for the current index, with no scan restart.
- Reset mid-operation:
  - Stimulus: assert resetn=0 with load=1 during scan index 2.
  - Required: next edge gives an_n=1111 and shadow=0; after release, scan restarts at index 0 showing SEG_0.
